// File: rtl/apb_controller_if.sv
// apb_controller_if
//   Groups the AHB-side request/response and APB-side signals of the
//   AHB-to-APB bridge controller. Clock and reset stay outside as plain ports.
//
//   AHB side : valid, Haddr, Hwrite, Hwdata (in); Hreadyout, Hrdata (out)
//   APB side : Prdata (in); Penable, Pwrite, Pselx, Paddr, Pwdata (out)
//
//   modport slave  : the controller's view
//   modport master : the view of whatever drives the controller
interface apb_controller_if;
    logic        valid;
    logic [31:0] Haddr;
    logic        Hwrite;
    logic [31:0] Hwdata;
    logic [31:0] Prdata;
    logic        Penable;
    logic        Pwrite;
    logic [2:0]  Pselx;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic        Hreadyout;
    logic [31:0] Hrdata;

    modport slave (
        input  valid, Haddr, Hwrite, Hwdata, Prdata,
        output Penable, Pwrite, Pselx, Paddr, Pwdata, Hreadyout, Hrdata
    );

    modport master (
        output valid, Haddr, Hwrite, Hwdata, Prdata,
        input  Penable, Pwrite, Pselx, Paddr, Pwdata, Hreadyout, Hrdata
    );
endinterface

// File: rtl/apb_controller.sv
// apb_controller
//   Accepts qualified AHB transfers, decodes the address into a one-hot APB
//   slave select and sequences the APB SETUP/ENABLE phases. Supports one
//   pending transfer captured while a write is waiting for its data phase.
//
//   Ports:
//     Hclk    : bridge clock, rising edge
//     Hresetn : asynchronous active-low reset
//     bus     : apb_controller_if.slave (AHB request/response + APB signals)
//
//   All APB outputs and Hreadyout are decoded from registered state only;
//   Hrdata passes Prdata through during a selected read ENABLE.
module apb_controller #(
    parameter logic [31:0] SLV0_BASE = 32'h8000_0000,
    parameter logic [31:0] SLV1_BASE = 32'h8400_0000,
    parameter logic [31:0] SLV2_BASE = 32'h8800_0000,
    parameter logic [31:0] SLV_SIZE  = 32'h0400_0000
) (
    input logic              Hclk,
    input logic              Hresetn,
    apb_controller_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_RENABLE,
        ST_WWAIT,
        ST_WRITE,
        ST_WENABLE,
        ST_WRITEP,
        ST_WENABLEP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [2:0]  sel_q, sel_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] addr_p_q, addr_p_d;
    logic        write_p_q, write_p_d;
    logic [2:0]  sel_p_q, sel_p_d;

    // Unsigned offset compare: wraps below the base, so one compare covers
    // both region bounds.
    function automatic logic [2:0] decode(input logic [31:0] a);
        logic [2:0] s;
        s[0] = (a - SLV0_BASE) < SLV_SIZE;
        s[1] = (a - SLV1_BASE) < SLV_SIZE;
        s[2] = (a - SLV2_BASE) < SLV_SIZE;
        return s;
    endfunction

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        write_d   = write_q;
        sel_d     = sel_q;
        wdata_d   = wdata_q;
        addr_p_d  = addr_p_q;
        write_p_d = write_p_q;
        sel_p_d   = sel_p_q;
        case (state_q)
            ST_IDLE, ST_RENABLE, ST_WENABLE: begin
                if (bus.valid) begin
                    addr_d  = bus.Haddr;
                    write_d = bus.Hwrite;
                    sel_d   = decode(bus.Haddr);
                    state_d = bus.Hwrite ? ST_WWAIT : ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ:  state_d = ST_RENABLE;
            ST_WWAIT: begin
                wdata_d = bus.Hwdata;
                if (bus.valid) begin
                    addr_p_d  = bus.Haddr;
                    write_p_d = bus.Hwrite;
                    sel_p_d   = decode(bus.Haddr);
                    state_d   = ST_WRITEP;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE:  state_d = ST_WENABLE;
            ST_WRITEP: state_d = ST_WENABLEP;
            ST_WENABLEP: begin
                addr_d  = addr_p_q;
                write_d = write_p_q;
                sel_d   = sel_p_q;
                // The stall keeps the pending write's data on Hwdata here.
                if (write_p_q) begin
                    wdata_d = bus.Hwdata;
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_READ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            write_q   <= 1'b0;
            sel_q     <= '0;
            wdata_q   <= '0;
            addr_p_q  <= '0;
            write_p_q <= 1'b0;
            sel_p_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            sel_q     <= sel_d;
            wdata_q   <= wdata_d;
            addr_p_q  <= addr_p_d;
            write_p_q <= write_p_d;
            sel_p_q   <= sel_p_d;
        end
    end

    logic apb_active;
    logic apb_write;

    always_comb begin
        apb_active = 1'b0;
        apb_write  = 1'b0;
        case (state_q)
            ST_READ, ST_RENABLE: apb_active = 1'b1;
            ST_WRITE, ST_WENABLE, ST_WRITEP, ST_WENABLEP: begin
                apb_active = 1'b1;
                apb_write  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.Penable   = (state_q == ST_RENABLE) || (state_q == ST_WENABLE) ||
                           (state_q == ST_WENABLEP);
    assign bus.Pwrite    = apb_write;
    assign bus.Pselx     = apb_active ? sel_q : 3'b000;
    assign bus.Paddr     = addr_q;
    assign bus.Pwdata    = wdata_q;
    assign bus.Hreadyout = (state_q == ST_IDLE) || (state_q == ST_RENABLE) ||
                           (state_q == ST_WWAIT) || (state_q == ST_WENABLE);
    assign bus.Hrdata    = ((state_q == ST_RENABLE) && (sel_q != 3'b000)) ?
                           bus.Prdata : '0;

endmodule

// File: tb/tb_apb_controller.sv
// tb_apb_controller
//   Directed stimulus for apb_controller. A transfer-level scoreboard records
//   every AHB transfer accepted (Hreadyout & valid) together with the write
//   data of its data phase, and each APB ENABLE cycle must retire the oldest
//   such transfer with the slave select implied by the address map.
//   Directed literal expectations pin cycle timing and specific values.
module tb_apb_controller;

    logic Hclk = 1'b0;
    logic Hresetn;
    always #5 Hclk = ~Hclk;

    apb_controller_if bus ();

    apb_controller #(
        .SLV0_BASE(32'h8000_0000),
        .SLV1_BASE(32'h8400_0000),
        .SLV2_BASE(32'h8800_0000),
        .SLV_SIZE (32'h0400_0000)
    ) dut (
        .Hclk   (Hclk),
        .Hresetn(Hresetn),
        .bus    (bus)
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Address map written as plain range tests.
    function automatic logic [2:0] exp_sel(input logic [31:0] a);
        if (a >= 32'h8000_0000 && a < 32'h8400_0000) return 3'b001;
        if (a >= 32'h8400_0000 && a < 32'h8800_0000) return 3'b010;
        if (a >= 32'h8800_0000 && a < 32'h8C00_0000) return 3'b100;
        return 3'b000;
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
    } xfer_t;

    xfer_t       sb[$];
    logic        need_fill = 1'b0;
    logic        prev_en = 1'b0;
    logic [2:0]  prev_sel;
    logic [31:0] prev_addr, prev_wdata;
    logic        prev_write;

    always @(negedge Hclk) begin
        if (!Hresetn) begin
            sb.delete();
            need_fill = 1'b0;
            prev_en   = 1'b0;
        end else begin
            xfer_t t;
            if (need_fill && sb.size() > 0) begin
                t = sb[sb.size()-1];
                t.wdata = bus.Hwdata;
                sb[sb.size()-1] = t;
            end
            need_fill = 1'b0;
            chk("pselx_onehot", 32'($countones(bus.Pselx) <= 1), 32'd1);
            if (sb.size() == 0) begin
                chk("idle_pselx", 32'(bus.Pselx), 32'd0);
                chk("idle_penable", 32'(bus.Penable), 32'd0);
                chk("idle_hready", 32'(bus.Hreadyout), 32'd1);
            end
            if (bus.Penable) begin
                chk("enable_after_setup", 32'(prev_en), 32'd0);
                chk("setup_sel_stable", 32'(bus.Pselx), 32'(prev_sel));
                chk("setup_addr_stable", bus.Paddr, prev_addr);
                chk("setup_write_stable", 32'(bus.Pwrite), 32'(prev_write));
                chk("setup_wdata_stable", bus.Pwdata, prev_wdata);
                chk("enable_has_xfer", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    t = sb.pop_front();
                    chk("sb_sel", 32'(bus.Pselx), 32'(exp_sel(t.addr)));
                    chk("sb_addr", bus.Paddr, t.addr);
                    chk("sb_write", 32'(bus.Pwrite), 32'(t.write));
                    if (t.write) begin
                        chk("sb_wdata", bus.Pwdata, t.wdata);
                    end else begin
                        chk("sb_rdata", bus.Hrdata,
                            (exp_sel(t.addr) != 3'b000) ? bus.Prdata : 32'd0);
                        chk("sb_read_ready", 32'(bus.Hreadyout), 32'd1);
                    end
                end
            end
            if (bus.Hreadyout && bus.valid) begin
                t.addr  = bus.Haddr;
                t.write = bus.Hwrite;
                t.wdata = '0;
                sb.push_back(t);
                need_fill = bus.Hwrite;
            end
            prev_en    = bus.Penable;
            prev_sel   = bus.Pselx;
            prev_addr  = bus.Paddr;
            prev_write = bus.Pwrite;
            prev_wdata = bus.Pwdata;
        end
    end

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [31:0] a);
        bus.valid  = v;
        bus.Hwrite = w;
        bus.Haddr  = a;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        Hresetn    = 1'b0;
        bus.valid  = 1'b0;
        bus.Haddr  = '0;
        bus.Hwrite = 1'b0;
        bus.Hwdata = '0;
        bus.Prdata = '0;
        #1;
        chk("rst_penable", 32'(bus.Penable), 32'd0);
        chk("rst_pwrite", 32'(bus.Pwrite), 32'd0);
        chk("rst_pselx", 32'(bus.Pselx), 32'd0);
        chk("rst_paddr", bus.Paddr, 32'd0);
        chk("rst_pwdata", bus.Pwdata, 32'd0);
        chk("rst_hready", 32'(bus.Hreadyout), 32'd1);
        repeat (2) tick();
        Hresetn = 1'b1;
        tick();

        // Reset asserted in the middle of a write ENABLE.
        drive(1'b1, 1'b1, 32'h8000_0040);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        bus.Hwdata = 32'h7777_0000;
        tick();
        tick();
        chk("pre_rst_penable", 32'(bus.Penable), 32'd1);
        #2 Hresetn = 1'b0;
        #1;
        chk("midrst_penable", 32'(bus.Penable), 32'd0);
        chk("midrst_pselx", 32'(bus.Pselx), 32'd0);
        chk("midrst_hready", 32'(bus.Hreadyout), 32'd1);
        tick();
        Hresetn = 1'b1;
        tick();
        chk("post_rst_hready", 32'(bus.Hreadyout), 32'd1);
        chk("post_rst_penable", 32'(bus.Penable), 32'd0);

        // Single read.
        drive(1'b1, 1'b0, 32'h8000_0010);
        bus.Prdata = 32'hDEAD_BEEF;
        tick();
        drive(1'b0, 1'b0, 32'h0);
        chk("rd_setup_pselx", 32'(bus.Pselx), 32'b001);
        chk("rd_setup_paddr", bus.Paddr, 32'h8000_0010);
        chk("rd_setup_penable", 32'(bus.Penable), 32'd0);
        chk("rd_setup_hready", 32'(bus.Hreadyout), 32'd0);
        tick();
        chk("rd_en_penable", 32'(bus.Penable), 32'd1);
        chk("rd_en_hready", 32'(bus.Hreadyout), 32'd1);
        chk("rd_en_hrdata", bus.Hrdata, 32'hDEAD_BEEF);
        tick();
        chk("rd_done_penable", 32'(bus.Penable), 32'd0);

        // Single write.
        drive(1'b1, 1'b1, 32'h8400_0004);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        bus.Hwdata = 32'h1234_5678;
        chk("wr_wait_hready", 32'(bus.Hreadyout), 32'd1);
        chk("wr_wait_pselx", 32'(bus.Pselx), 32'd0);
        tick();
        chk("wr_setup_pselx", 32'(bus.Pselx), 32'b010);
        chk("wr_setup_pwrite", 32'(bus.Pwrite), 32'd1);
        chk("wr_setup_pwdata", bus.Pwdata, 32'h1234_5678);
        chk("wr_setup_penable", 32'(bus.Penable), 32'd0);
        chk("wr_setup_hready", 32'(bus.Hreadyout), 32'd0);
        tick();
        chk("wr_en_penable", 32'(bus.Penable), 32'd1);
        chk("wr_en_hready", 32'(bus.Hreadyout), 32'd1);
        tick();

        // Back-to-back write then read.
        drive(1'b1, 1'b1, 32'h8800_0000);
        tick();
        drive(1'b1, 1'b0, 32'h8000_0008);
        bus.Hwdata = 32'hAAAA_5555;
        bus.Prdata = 32'h0BAD_F00D;
        tick();
        drive(1'b0, 1'b0, 32'h0);
        chk("wr_rd_writep_hready", 32'(bus.Hreadyout), 32'd0);
        chk("wr_rd_writep_pselx", 32'(bus.Pselx), 32'b100);
        chk("wr_rd_writep_pwdata", bus.Pwdata, 32'hAAAA_5555);
        tick();
        chk("wr_rd_wenp_penable", 32'(bus.Penable), 32'd1);
        chk("wr_rd_wenp_hready", 32'(bus.Hreadyout), 32'd0);
        tick();
        chk("wr_rd_read_pselx", 32'(bus.Pselx), 32'b001);
        chk("wr_rd_read_paddr", bus.Paddr, 32'h8000_0008);
        chk("wr_rd_read_pwrite", 32'(bus.Pwrite), 32'd0);
        chk("wr_rd_read_hready", 32'(bus.Hreadyout), 32'd0);
        tick();
        chk("wr_rd_ren_penable", 32'(bus.Penable), 32'd1);
        chk("wr_rd_ren_hrdata", bus.Hrdata, 32'h0BAD_F00D);
        tick();

        // Back-to-back write then write; second data held through the stall.
        drive(1'b1, 1'b1, 32'h8000_0020);
        tick();
        drive(1'b1, 1'b1, 32'h8400_0030);
        bus.Hwdata = 32'h1111_2222;
        tick();
        drive(1'b0, 1'b0, 32'h0);
        bus.Hwdata = 32'hCAFE_0001;
        chk("wr_wr_setup1_pwdata", bus.Pwdata, 32'h1111_2222);
        chk("wr_wr_setup1_pselx", 32'(bus.Pselx), 32'b001);
        tick();
        chk("wr_wr_wenp_hready", 32'(bus.Hreadyout), 32'd0);
        tick();
        chk("wr_wr_setup2_pwdata", bus.Pwdata, 32'hCAFE_0001);
        chk("wr_wr_setup2_pselx", 32'(bus.Pselx), 32'b010);
        chk("wr_wr_setup2_paddr", bus.Paddr, 32'h8400_0030);
        chk("wr_wr_setup2_hready", 32'(bus.Hreadyout), 32'd0);
        tick();
        chk("wr_wr_en2_penable", 32'(bus.Penable), 32'd1);
        chk("wr_wr_en2_hready", 32'(bus.Hreadyout), 32'd1);
        tick();

        // Out-of-range read.
        drive(1'b1, 1'b0, 32'h0000_0100);
        bus.Prdata = 32'hFFFF_FFFF;
        tick();
        drive(1'b0, 1'b0, 32'h0);
        chk("oor_setup_pselx", 32'(bus.Pselx), 32'd0);
        chk("oor_setup_penable", 32'(bus.Penable), 32'd0);
        tick();
        chk("oor_en_pselx", 32'(bus.Pselx), 32'd0);
        chk("oor_en_penable", 32'(bus.Penable), 32'd1);
        chk("oor_en_hrdata", bus.Hrdata, 32'd0);
        tick();
        chk("oor_done_penable", 32'(bus.Penable), 32'd0);

        // Read, then a write issued during the read ENABLE.
        drive(1'b1, 1'b0, 32'h8800_0040);
        bus.Prdata = 32'h1357_9BDF;
        tick();
        drive(1'b0, 1'b0, 32'h0);
        tick();
        chk("rd_wr_ren_hrdata", bus.Hrdata, 32'h1357_9BDF);
        drive(1'b1, 1'b1, 32'h8000_0004);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        bus.Hwdata = 32'h5A5A_A5A5;
        chk("rd_wr_wait_hready", 32'(bus.Hreadyout), 32'd1);
        tick();
        chk("rd_wr_setup_pwdata", bus.Pwdata, 32'h5A5A_A5A5);
        chk("rd_wr_setup_pselx", 32'(bus.Pselx), 32'b001);
        tick();
        chk("rd_wr_en_penable", 32'(bus.Penable), 32'd1);
        repeat (3) tick();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/apb_controller.md
Name: apb_controller

Overview:
- Upstream neighbour of the APB interface stage in the AHB-APB bridge.
- Accepts qualified AHB transfers and decodes the captured address into a 3-bit one-hot Pselx.
- Sequences APB SETUP/ENABLE phases, driving Penable, Pwrite, Pselx, Paddr and Pwdata into the APB interface stage.
- Returns Hreadyout and Hrdata to the AHB side and supports back-to-back (pipelined) AHB transfers.

Parameters:
- SLV0_BASE, 32'h8000_0000, base address of APB slave 0.
- SLV1_BASE, 32'h8400_0000, base address of APB slave 1.
- SLV2_BASE, 32'h8800_0000, base address of APB slave 2.
- SLV_SIZE, 32'h0400_0000, size of each slave region in bytes.

Ports:
- Hclk  input  1  bridge clock, rising edge.
- Hresetn  input  1  asynchronous active-low reset.
- valid  input  1  AHB transfer qualified this cycle (HSEL & HREADY & HTRANS NONSEQ/SEQ), address phase.
- Haddr  input  32  AHB address, valid with valid.
- Hwrite  input  1  AHB direction, valid with valid.
- Hwdata  input  32  AHB write data, valid one cycle after the address phase (data phase).
- Prdata  input  32  read data returned from the APB interface stage.
- Penable  output  1  APB enable.
- Pwrite  output  1  APB direction.
- Pselx  output  3  one-hot APB slave select.
- Paddr  output  32  APB address.
- Pwdata  output  32  APB write data.
- Hreadyout  output  1  AHB ready; 0 stalls the AHB master.
- Hrdata  output  32  AHB read data.

Behaviour:
- Reset: Hresetn low asynchronously forces state ST_IDLE and clears all holding registers.
  - Outputs during reset: Penable=0, Pwrite=0, Pselx=0, Paddr=0, Pwdata=0, Hreadyout=1.
  - Reset mid-transfer aborts the transfer with no completion.
- Output timing: APB outputs and Hreadyout decode only from the state register and holding registers. There is no combinational path from AHB inputs to them.
- Hrdata: equals Prdata in ST_RENABLE when Pselx!=0; otherwise 0.
- Holding registers:
  - Current transfer: addr_q, write_q, sel_q, wdata_q.
  - Pending transfer: addr_p, write_p, sel_p.
- Address decode: slave k is selected when BASEk <= addr < BASEk+SLV_SIZE, giving Pselx bit k.
  - Out-of-range address: the transfer still runs full APB timing with Pselx=3'b000, writes are dropped, and reads return 0.
- Address capture: occurs in every state where Hreadyout=1 and valid=1.
- States and transitions:
  - ST_IDLE: Hreadyout=1, APB outputs idle (Penable=0, Pselx=0).
    - valid & !Hwrite → ST_READ (capture to _q).
    - valid & Hwrite → ST_WWAIT (capture to _q).
    - Otherwise stay.
  - ST_READ: SETUP phase. Pselx=sel_q, Paddr=addr_q, Pwrite=0, Penable=0, Hreadyout=0. Always → ST_RENABLE.
  - ST_RENABLE: Penable=1, other APB signals held, Hreadyout=1; the read completes on AHB this cycle. Next state is the same decision as ST_IDLE, with capture to _q.
  - ST_WWAIT: Hreadyout=1, APB idle; wdata_q <= Hwdata.
    - valid → ST_WRITEP (capture the new transfer to _p).
    - Otherwise → ST_WRITE.
  - ST_WRITE: SETUP. Pselx=sel_q, Paddr=addr_q, Pwdata=wdata_q, Pwrite=1, Penable=0, Hreadyout=0. → ST_WENABLE.
  - ST_WENABLE: Penable=1, Hreadyout=1. Next state is the same decision as ST_IDLE.
  - ST_WRITEP: same APB SETUP as ST_WRITE, Hreadyout=0 (stalls the pending transfer's data phase). → ST_WENABLEP.
  - ST_WENABLEP: Penable=1, Hreadyout=0; _q <= _p.
    - write_p=1: wdata_q <= Hwdata (held stable by the stall), → ST_WRITE.
    - write_p=0: → ST_READ.
- Latency:
  - Read: address phase in cycle N; SETUP in N+1; ENABLE plus Hreadyout=1 in N+2.
  - Write: address in N; WWAIT in N+1; SETUP in N+2; ENABLE in N+3.
- Invariants:
  - Penable=1 only in the cycle immediately after a SETUP cycle with identical Pselx/Paddr/Pwrite/Pwdata.
  - At most one pending transfer; Hreadyout=0 guarantees no further capture.
- valid while Hreadyout=0 is ignored, because the master is stalled by protocol.

Test Plan:
- Reset: assert Hresetn=0 mid ST_WENABLE → outputs immediately Penable=0, Pselx=0, Hreadyout=1; after release, state is ST_IDLE.
- Single read: valid=1, Hwrite=0, Haddr=32'h8000_0010; Prdata=32'hDEAD_BEEF.
  - Next cycle: Pselx=3'b001, Paddr=32'h8000_0010, Penable=0, Hreadyout=0.
  - Following cycle: Penable=1, Hreadyout=1, Hrdata=32'hDEAD_BEEF.
- Single write: Haddr=32'h8400_0004, then Hwdata=32'h1234_5678.
  - SETUP at N+2: Pselx=3'b010, Pwrite=1, Pwdata=32'h1234_5678.
  - ENABLE at N+3 with Hreadyout=1.
- Back-to-back write→read: write to 32'h8800_0000 immediately followed by a read of 32'h8000_0008 during ST_WWAIT.
  - State sequence: WRITEP, WENABLEP (Hreadyout=0 both), READ, RENABLE.
  - Second transfer uses Pselx=3'b001.
- Back-to-back write→write: the second write's data (32'hCAFE_0001) is held during the stall and appears on Pwdata in the second SETUP.
- Out-of-range read, Haddr=32'h0000_0100: Pselx=3'b000 throughout, Penable pulses once, Hrdata=0.
